// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time instruction-memory loader: state
// encodings, the default frame start byte, the order of frame fields, and a
// helper that decides whether a received word count is acceptable.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_pkg;

    // Loader state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    // Default frame start byte
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Frame field order as seen on the byte link
    typedef enum logic [2:0] {
        FLD_SYNC    = 3'd0,
        FLD_LEN_LO  = 3'd1,
        FLD_LEN_HI  = 3'd2,
        FLD_PAYLOAD = 3'd3,
        FLD_CSUM    = 3'd4
    } frame_field_t;

    // Word count must be non-zero and no larger than the memory allows.
    // Comparison is unsigned.
    function automatic logic len_ok(input logic [15:0] n, input int max_words);
        return (n != 16'd0) && (32'(n) <= $unsigned(max_words));
    endfunction

endpackage

// File: rtl/m_byte_packer.sv
// -----------------------------------------------------------------------------
// m_byte_packer
// Assembles four consecutive bytes into a little-endian 32-bit word. The
// first byte shifted in lands in bits [7:0]. When the fourth byte arrives the
// completed word is registered and word_valid pulses for exactly one cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   restart at byte 0 (start of a new payload)
//   shift_en   in   accept byte_in this cycle
//   byte_in    in   8-bit payload byte
//   byte_idx   out  position (0..3) the next accepted byte will take
//   word       out  last completed word (held until the next completion)
//   word_valid out  one-cycle pulse in the cycle after a word completes
// -----------------------------------------------------------------------------
module m_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic [31:0] word,
    output logic        word_valid
);

    // Only three bytes need holding; the fourth comes straight from byte_in.
    logic [23:0] sr_q;
    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= 24'd0;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                sr_q  <= 24'd0;
                idx_q <= 2'd0;
            end else if (shift_en) begin
                sr_q  <= {byte_in, sr_q[23:8]};
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q  <= {byte_in, sr_q};
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign byte_idx   = idx_q;
    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/m_imem_loader.sv
// -----------------------------------------------------------------------------
// m_imem_loader
// Boot-time program loader. Parses a framed byte stream
//   SYNC, LEN_LO, LEN_HI, 4*N payload bytes (LSB first per word), CSUM
// writes the payload words into instruction memory starting at word 0 and
// holds the processor in reset until a frame with a matching XOR checksum
// has been received.
//
// State table:
//   state | meaning
//   IDLE  | after reset, waiting for SYNC; other bytes dropped
//   LEN0  | next byte is LEN_LO
//   LEN1  | next byte is LEN_HI; N is checked here
//   DATA  | payload bytes; a memory write per four bytes
//   CSUM  | next byte is the checksum
//   DONE  | image loaded, processor released; SYNC starts a reload
//   ERR   | frame rejected, processor held; SYNC starts a reload
//
// Ports:
//   w_clk       in   clock
//   w_rst_n     in   asynchronous active-low reset
//   w_rx_valid  in   byte present on w_rx_data
//   w_rx_data   in   incoming byte
//   w_rx_ready  out  loader accepts a byte (always 1 once out of reset)
//   w_mem_we    out  one-cycle write strobe to instruction memory
//   w_mem_addr  out  word address of the write
//   w_mem_din   out  word being written
//   w_proc_rst  out  active-high processor reset, low only when loaded
//   w_done      out  last frame loaded with a good checksum
//   w_err       out  last frame rejected
//   w_count     out  words written in the current or last frame
// -----------------------------------------------------------------------------
module m_imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 11,
    parameter int         MAX_WORDS = 2048,
    parameter logic [7:0] SYNC      = SYNC_BYTE
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rx_valid,
    input  logic [7:0]        w_rx_data,
    output logic              w_rx_ready,
    output logic              w_mem_we,
    output logic [ADDR_W-1:0] w_mem_addr,
    output logic [31:0]       w_mem_din,
    output logic              w_proc_rst,
    output logic              w_done,
    output logic              w_err,
    output logic [ADDR_W:0]   w_count
);

    logic [2:0]        state_q;
    logic              ready_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   idx_q;
    logic [7:0]        acc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              proc_rst_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   count_q;

    logic              fire;
    logic [15:0]       len_n;
    logic [ADDR_W:0]   idx_inc;
    logic              last_word;
    logic              pk_clear;
    logic              pk_shift;
    logic [1:0]        pk_byte_idx;

    assign fire      = w_rx_valid && ready_q;
    assign len_n     = {w_rx_data, len_lo_q};
    assign idx_inc   = idx_q + 1'b1;
    assign last_word = (32'(idx_inc) == 32'(len_q));

    // The packer restarts on LEN_HI regardless of whether N is accepted;
    // a rejected frame never reaches DATA so the restart is harmless.
    assign pk_clear  = fire && (state_q == ST_LEN1);
    assign pk_shift  = fire && (state_q == ST_DATA);

    m_byte_packer u_packer (
        .clk        (w_clk),
        .rst_n      (w_rst_n),
        .clear      (pk_clear),
        .shift_en   (pk_shift),
        .byte_in    (w_rx_data),
        .byte_idx   (pk_byte_idx),
        .word       (w_mem_din),
        .word_valid (w_mem_we)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            idx_q      <= '0;
            acc_q      <= 8'd0;
            addr_q     <= '0;
            proc_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            ready_q <= 1'b1;
            if (fire) begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_rx_data == SYNC)
                            state_q <= ST_LEN0;
                    end
                    ST_LEN0: begin
                        len_lo_q <= w_rx_data;
                        state_q  <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        if (len_ok(len_n, MAX_WORDS)) begin
                            len_q   <= len_n;
                            idx_q   <= '0;
                            acc_q   <= 8'd0;
                            state_q <= ST_DATA;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end
                    ST_DATA: begin
                        acc_q <= acc_q ^ w_rx_data;
                        // Address and count update together with the packer's
                        // write strobe so all three are valid in the same cycle.
                        if (pk_byte_idx == 2'd3) begin
                            idx_q   <= idx_inc;
                            addr_q  <= idx_q[ADDR_W-1:0];
                            count_q <= idx_inc;
                            if (last_word)
                                state_q <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (w_rx_data == acc_q) begin
                            done_q     <= 1'b1;
                            proc_rst_q <= 1'b0;
                            state_q    <= ST_DONE;
                        end else begin
                            err_q      <= 1'b1;
                            state_q    <= ST_ERR;
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        if (w_rx_data == SYNC) begin
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            count_q    <= '0;
                            proc_rst_q <= 1'b1;
                            state_q    <= ST_LEN0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_rx_ready = ready_q;
    assign w_mem_addr = addr_q;
    assign w_proc_rst = proc_rst_q;
    assign w_done     = done_q;
    assign w_err      = err_q;
    assign w_count    = count_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_m_imem_loader
// Directed frames for the instruction-memory loader. Expected writes are queued
// as bytes are sent; a monitor branch pops and compares on every write strobe.
// Frame status outputs are compared against hand-derived values after each
// frame.
// -----------------------------------------------------------------------------
module tb_m_imem_loader;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 2048;
    localparam logic [7:0] SYNC = 8'hA5;

    logic              w_clk      = 1'b0;
    logic              w_rst_n    = 1'b1;
    logic              w_rx_valid = 1'b0;
    logic [7:0]        w_rx_data  = 8'h00;
    logic              w_rx_ready;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_din;
    logic              w_proc_rst;
    logic              w_done;
    logic              w_err;
    logic [ADDR_W:0]   w_count;

    always #5 w_clk = ~w_clk;

    m_imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .SYNC      (SYNC)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_rx_valid (w_rx_valid),
        .w_rx_data  (w_rx_data),
        .w_rx_ready (w_rx_ready),
        .w_mem_we   (w_mem_we),
        .w_mem_addr (w_mem_addr),
        .w_mem_din  (w_mem_din),
        .w_proc_rst (w_proc_rst),
        .w_done     (w_done),
        .w_err      (w_err),
        .w_count    (w_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_din_q[$];
    logic [31:0] frame_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input int done, input int err,
                                input int prst, input int cnt);
        check({tag, "/done"},     32'(w_done),     32'(done));
        check({tag, "/err"},      32'(w_err),      32'(err));
        check({tag, "/proc_rst"}, 32'(w_proc_rst), 32'(prst));
        check({tag, "/count"},    32'(w_count),    32'(cnt));
    endtask

    task automatic check_sb_empty(input string tag);
        check({tag, "/pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge w_clk);
            w_rx_valid = 1'b0;
        end
    endtask

    // Presents one byte for the next rising edge; valid stays high until the
    // next call or drive_idle, so back-to-back calls give one byte per cycle.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps && ($urandom_range(0, 2) == 0))
            drive_idle(int'($urandom_range(1, 3)));
        @(negedge w_clk);
        budget = 0;
        while (!w_rx_ready && budget < 16) begin
            w_rx_valid = 1'b0;
            @(negedge w_clk);
            budget++;
        end
        if (!w_rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_ready: still 0 after %0d cycles, expected 1", budget);
        end
        w_rx_valid = 1'b1;
        w_rx_data  = b;
    endtask

    // Sends frame_words as a frame with length n. The checksum is computed
    // here and XORed with csum_flip to create bad frames.
    task automatic send_frame(input bit send_sync, input logic [15:0] n,
                              input logic [7:0] csum_flip, input bit gaps);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        if (send_sync)
            send_byte(SYNC, gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        for (int i = 0; i < frame_words.size(); i++) begin
            w = frame_words[i];
            for (int j = 0; j < 4; j++) begin
                if (j == 3) begin
                    exp_addr_q.push_back(32'(i));
                    exp_din_q.push_back(w);
                end
                cs = cs ^ w[8*j +: 8];
                send_byte(w[8*j +: 8], gaps);
            end
        end
        send_byte(cs ^ csum_flip, gaps);
        drive_idle(2);
    endtask

    initial begin
        fork
            begin : monitor
                logic [31:0] a;
                logic [31:0] d;
                forever begin
                    @(negedge w_clk);
                    if (w_rst_n && w_mem_we) begin
                        if (exp_addr_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                                     w_mem_addr, w_mem_din);
                        end else begin
                            a = exp_addr_q.pop_front();
                            d = exp_din_q.pop_front();
                            check("write_addr",  32'(w_mem_addr), a);
                            check("write_data",  w_mem_din,       d);
                            check("write_count", 32'(w_count),    a + 32'd1);
                        end
                    end
                end
            end
            begin : watchdog
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
                $fatal(1, "watchdog expired");
            end
        join_none

        // ---- reset values ----
        #2 w_rst_n = 1'b0;
        drive_idle(3);
        check("rst/rx_ready", 32'(w_rx_ready), 32'd0);
        check("rst/mem_we",   32'(w_mem_we),   32'd0);
        check("rst/mem_addr", 32'(w_mem_addr), 32'd0);
        check("rst/mem_din",  w_mem_din,       32'd0);
        check_status("rst", 0, 0, 1, 0);
        @(negedge w_clk);
        w_rst_n = 1'b1;

        // ---- basic load: A5 02 00 | 05 00 01 20 | 00 00 00 00 | 24 ----
        frame_words = '{32'h2001_0005, 32'h0000_0000};
        send_frame(1'b1, 16'd2, 8'h00, 1'b0);
        check_status("basic", 1, 0, 0, 2);
        check_sb_empty("basic");

        // ---- bad checksum: same frame, CSUM ^ 0x01 ----
        send_frame(1'b1, 16'd2, 8'h01, 1'b0);
        check_status("bad_csum", 0, 1, 1, 2);
        check_sb_empty("bad_csum");

        // ---- N = 0 ----
        send_byte(SYNC, 1'b0);
        drive_idle(1);
        check_status("n0_sync", 0, 0, 1, 0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        drive_idle(2);
        check_status("n0", 0, 1, 1, 0);

        // ---- N = MAX_WORDS + 1 (01 08), trailing bytes must not write ----
        send_byte(SYNC, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        drive_idle(3);
        check_status("n_over", 0, 1, 1, 0);

        // ---- N = MAX_WORDS ----
        frame_words.delete();
        for (int i = 0; i < MAX_WORDS; i++)
            frame_words.push_back({16'(i) ^ 16'h5A5A, 16'(i)});
        send_frame(1'b1, 16'd2048, 8'h00, 1'b0);
        check_status("n_max", 1, 0, 0, 2048);
        check("n_max/last_addr", 32'(w_mem_addr), 32'h7FF);
        check_sb_empty("n_max");

        // ---- reload: SYNC from DONE re-asserts processor reset ----
        send_byte(SYNC, 1'b0);
        drive_idle(1);
        check_status("reload_sync", 0, 0, 1, 0);
        frame_words = '{32'hCAFE_F00D};
        send_frame(1'b0, 16'd1, 8'h00, 1'b0);
        check_status("reload", 1, 0, 0, 1);
        check("reload/addr", 32'(w_mem_addr), 32'h0);
        check_sb_empty("reload");

        // ---- reset after 2 payload words of a 4-word frame ----
        frame_words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        send_byte(SYNC, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3) begin
                    exp_addr_q.push_back(32'(i));
                    exp_din_q.push_back(frame_words[i]);
                end
                send_byte(frame_words[i][8*j +: 8], 1'b0);
            end
        end
        drive_idle(2);
        check_status("partial", 0, 0, 1, 2);
        check_sb_empty("partial");
        @(negedge w_clk);
        w_rst_n = 1'b0;
        #1;
        check("midrst/rx_ready", 32'(w_rx_ready), 32'd0);
        check("midrst/mem_we",   32'(w_mem_we),   32'd0);
        check("midrst/mem_addr", 32'(w_mem_addr), 32'd0);
        check("midrst/mem_din",  w_mem_din,       32'd0);
        check_status("midrst", 0, 0, 1, 0);
        drive_idle(2);
        w_rst_n = 1'b1;

        // ---- garbage then basic frame with random valid gaps ----
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h13, 1'b1);
        drive_idle(2);
        check_status("garbage", 0, 0, 1, 0);
        frame_words = '{32'h2001_0005, 32'h0000_0000};
        send_frame(1'b1, 16'd2, 8'h00, 1'b1);
        check_status("gaps", 1, 0, 0, 2);
        check_sb_empty("gaps");

        drive_idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
